// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM state encoding
// and the packed command-entry layout stored in the FIFO.
package alu_pkg;
    localparam int unsigned OPC_W     = 4;
    localparam int unsigned OPERAND_W = 16;
    localparam int unsigned REP_W     = 4;
    localparam int unsigned ACC_W     = 32;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned ENTRY_W   = OPC_W + OPERAND_W + REP_W;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OPC_NOOP  = 4'h0;
    localparam opcode_t OPC_RESET = 4'h1;
    localparam opcode_t OPC_ADD   = 4'h2;
    localparam opcode_t OPC_SUB   = 4'h3;
    localparam opcode_t OPC_MUL   = 4'h4;
    localparam opcode_t OPC_DIV   = 4'h5;
    localparam opcode_t OPC_AND   = 4'h6;
    localparam opcode_t OPC_OR    = 4'h7;
    localparam opcode_t OPC_SHL   = 4'h8;
    localparam opcode_t OPC_XOR   = 4'h9;
    localparam opcode_t OPC_MAX   = OPC_XOR;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_DIVCHK = 2'd2
    } seq_state_t;

    typedef struct packed {
        opcode_t                opcode;
        logic [OPERAND_W-1:0]   operand;
        logic [REP_W-1:0]       rpt;
    } cmd_entry_t;
endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Host command handshake bundle: valid/ready plus the opcode, operand and repeat payload.
interface alu_cmd_sequencer_if;
    import alu_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    opcode_t              cmd_opcode;
    logic [OPERAND_W-1:0] cmd_operand;
    logic [REP_W-1:0]     cmd_repeat;

    modport master (output cmd_valid, cmd_opcode, cmd_operand, cmd_repeat, input cmd_ready);
    modport slave  (input cmd_valid, cmd_opcode, cmd_operand, cmd_repeat, output cmd_ready);
endinterface

// File: rtl/alu_cmd_sequencer_cmd_fifo.sv
// Synchronous FIFO with wrapping power-of-two pointers; head entry is visible on rdata.
module cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers host commands and issues them to the ALU one per clock with repeat,
// screening illegal opcodes and divide-by-zero against the live accumulator.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_cmd_sequencer_if.slave   cmd,
    input  logic                 pause,
    input  logic [ACC_W-1:0]     acc_in,
    output opcode_t              alu_opcode,
    output logic [OPERAND_W-1:0] alu_a,
    output logic                 busy,
    output logic                 err_illegal,
    output logic                 err_div0,
    output logic [CNT_W-1:0]     issue_count
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    seq_state_t           state, state_d;
    logic [REP_W-1:0]     rep_cnt, rep_cnt_d;
    opcode_t              cur_opc, cur_opc_d;
    logic [OPERAND_W-1:0] cur_a, cur_a_d;

    cmd_entry_t           head;
    cmd_entry_t           wentry;
    logic                 full, empty, push, pop;
    logic [CW-1:0]        count, count_d;

    opcode_t              alu_opcode_d;
    logic [OPERAND_W-1:0] alu_a_d;
    logic                 busy_d, err_illegal_d, err_div0_d;
    logic [CNT_W-1:0]     issue_count_d;

    assign wentry        = {cmd.cmd_opcode, cmd.cmd_operand, cmd.cmd_repeat};
    assign push          = cmd.cmd_valid && !full;
    assign cmd.cmd_ready = !full;
    assign count_d       = count + CW'(push) - CW'(pop);

    cmd_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wentry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_d;
    end

    // Next state, head pop and repeat bookkeeping; pause freezes EXEC/DIVCHK in place.
    always_comb begin
        state_d   = state;
        rep_cnt_d = rep_cnt;
        cur_opc_d = cur_opc;
        cur_a_d   = cur_a;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty && !pause) begin
                    pop       = 1'b1;
                    rep_cnt_d = head.rpt;
                    cur_opc_d = head.opcode;
                    cur_a_d   = head.operand;
                    if (head.opcode > OPC_MAX)       state_d = ST_IDLE;
                    else if (head.opcode == OPC_DIV) state_d = ST_DIVCHK;
                    else                             state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!pause) begin
                    if (rep_cnt == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        rep_cnt_d = rep_cnt - REP_W'(1);
                        state_d   = (cur_opc == OPC_DIV) ? ST_DIVCHK : ST_EXEC;
                    end
                end
            end
            ST_DIVCHK: begin
                if (!pause) state_d = (acc_in == '0) ? ST_IDLE : ST_EXEC;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        alu_opcode_d  = OPC_NOOP;
        alu_a_d       = '0;
        err_illegal_d = err_illegal;
        err_div0_d    = err_div0;
        issue_count_d = issue_count;
        busy_d        = (count_d != '0) || (state_d != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (pop && (head.opcode > OPC_MAX)) err_illegal_d = 1'b1;
            end
            ST_EXEC: begin
                if (!pause && (cur_opc != OPC_NOOP)) begin
                    alu_opcode_d  = cur_opc;
                    alu_a_d       = cur_a;
                    issue_count_d = issue_count + CNT_W'(1);
                end
            end
            ST_DIVCHK: begin
                if (!pause && (acc_in == '0)) err_div0_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_cnt     <= '0;
            cur_opc     <= OPC_NOOP;
            cur_a       <= '0;
            alu_opcode  <= OPC_NOOP;
            alu_a       <= '0;
            busy        <= 1'b0;
            err_illegal <= 1'b0;
            err_div0    <= 1'b0;
            issue_count <= '0;
        end else begin
            rep_cnt     <= rep_cnt_d;
            cur_opc     <= cur_opc_d;
            cur_a       <= cur_a_d;
            alu_opcode  <= alu_opcode_d;
            alu_a       <= alu_a_d;
            busy        <= busy_d;
            err_illegal <= err_illegal_d;
            err_div0    <= err_div0_d;
            issue_count <= issue_count_d;
        end
    end
endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command sequencer for the accumulator ALU breadboard. It buffers opcode/operand commands from a host through a valid/ready handshake in a small FIFO. It issues them to the ALU's opcode and A inputs one per clock, with optional repeat, and drives NOOP whenever no issue occurs. It screens illegal opcodes and divide-by-zero using the live accumulator value, and keeps sticky error flags and an issue counter.

## Interface
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  host command present
- cmd_ready  out  1  FIFO can accept; equals (count < DEPTH)
- cmd_opcode  in  4  ALU opcode (0000 NOOP … 1001 XOR)
- cmd_operand  in  16  operand for ALU A input
- cmd_repeat  in  4  extra executions (0 = run once, 15 = run 16 times)
- pause  in  1  freeze issue; host push still allowed
- acc_in  in  32  current accumulator value from ALU
- alu_opcode  out  4  registered opcode to ALU
- alu_a  out  16  registered operand to ALU
- busy  out  1  FIFO non-empty or command in execution
- err_illegal  out  1  sticky; opcode > 1001 dropped
- err_div0  out  1  sticky; DIV with acc_in == 0 dropped
- issue_count  out  16  count of opcodes actually issued (non-NOOP), wraps

## Operation
- Push occurs on a rising edge when cmd_valid and cmd_ready are both high. Entry = {opcode, operand, repeat}.
- cmd_ready is derived from the registered count only. A pop in the same cycle does not raise ready.
- The FSM has three states: IDLE, EXEC and DIVCHK.
- IDLE: drives NOOP. If the FIFO is non-empty and pause = 0, it pops the head and loads rep_cnt = repeat.
  - Head opcode > 1001: set err_illegal, drop the entry, stay in IDLE.
  - Head opcode DIV: go to DIVCHK.
  - Head opcode NOOP: consumes its repeat cycles in EXEC with no issue and no count.
  - Any other opcode: go to EXEC.
- EXEC: drives the opcode and operand for one cycle per iteration and increments issue_count for non-NOOP opcodes. When rep_cnt = 0, return to IDLE. Otherwise decrement rep_cnt; a DIV returns to DIVCHK, and any other opcode stays in EXEC.
- DIVCHK: drives NOOP for one bubble cycle so that acc_in reflects all prior issues.
  - acc_in == 0: set err_div0 and abandon every remaining repeat of this entry. Go to IDLE.
  - Otherwise go to EXEC.
- pause = 1 in EXEC or DIVCHK: drive NOOP, hold state and rep_cnt. Execution resumes exactly where it stopped.
- Error flags clear only on rst. issue_count wraps from FFFF to 0000.
- The RESET opcode (0001) is issued like any other opcode and counted. It does not affect the sequencer's own state.
- busy = (count ≠ 0) or (state ≠ IDLE).

## Timing
- All outputs are registered except cmd_ready, which is a combinational compare on the registered count.
- Reset values:
  - alu_opcode = 0000, alu_a = 0.
  - busy = 0, both error flags = 0, issue_count = 0.
  - FIFO empty, cmd_ready = 1, state IDLE.
- Latency, for a command pushed at edge N into an empty, unpaused FIFO:
  - Non-DIV: alu_opcode is valid after edge N+2 (one IDLE decision cycle). The accumulator updates at edge N+3.
  - DIV: adds one bubble, so alu_opcode is valid after edge N+3.
- Back-to-back non-DIV entries execute with one NOOP gap (the IDLE decision).
- Full FIFO: no push occurs even if a pop happens that cycle. Empty FIFO: no pop, NOOP driven.
- Reset asserted mid-execution: every register returns to its reset value immediately (asynchronous), FIFO contents are discarded, and alu_opcode = NOOP before the next edge.

## Structure
- Shared package alu_pkg holds:
  - Opcode constants NOOP…XOR (4-bit) and OPC_MAX = 1001.
  - The sequencer state encoding.
  - The FIFO entry width: 4 + 16 + 4 = 24 bits.
- One sub-module, cmd_fifo: a parameterised synchronous FIFO (DEPTH, WIDTH) with wrapping pointers, a count, and full/empty outputs.
- The FSM, repeat counter and error logic live in alu_cmd_sequencer.

## Test plan
- Reset, then push {ADD, 0003, repeat 0} → alu_opcode = 0010 and alu_a = 0003 for exactly one cycle, then NOOP; issue_count = 1; busy falls after the FIFO drains.
- Push {ADD, 0002, repeat 3} with the ALU starting from acc 0 → four consecutive ADD cycles; acc = 8; issue_count = 4.
- With acc = 0, push {DIV, 0006, repeat 2} → one DIVCHK bubble, then err_div0 = 1; no DIV is ever driven; issue_count is unchanged; the next entry still executes.
- With acc = 3, push {DIV, 0009, 0} → NOOP bubble, then DIV; acc becomes 3 (9/3).
- Push {1100, 0001, 0} followed by {XOR, 00FF, 0} → err_illegal = 1; the XOR is issued normally; err_illegal stays 1 until rst.
- Hold cmd_valid high with pause = 1 → exactly DEPTH pushes are accepted, then cmd_ready = 0. Deassert pause mid-repeat for a while to confirm it resumes with the same rep_cnt. Assert rst mid-EXEC → outputs return to reset values asynchronously and the FIFO is empty.
